// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad path (scanner, key queue, password FSM).
package keypad_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    HELD,
    RELEASING
  } debounce_state_t;

  localparam logic [KEY_W-1:0] KEY_A    = 4'hA;
  localparam logic [KEY_W-1:0] KEY_B    = 4'hB;
  localparam logic [KEY_W-1:0] KEY_C    = 4'hC;
  localparam logic [KEY_W-1:0] KEY_D    = 4'hD;
  localparam logic [KEY_W-1:0] KEY_STAR = 4'hE;
  localparam logic [KEY_W-1:0] KEY_HASH = 4'hF;

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flags and count derive from registered pointers.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = KEY_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign count   = wr_q - rd_q;
  assign head    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_data;
        wr_q                <= wr_q + PTR_ONE;
      end
      if (do_pop) rd_q <= rd_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/keypad_key_queue.sv
// Debounces the scanner's key level into one event per press and queues events for the FSM.
module keypad_key_queue
  import keypad_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [KEY_W-1:0]              raw_key,
  input  logic                          raw_valid,
  output logic [KEY_W-1:0]              out_key,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  debounce_state_t   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0]  cand_q, cand_d;
  logic              push_req, fifo_empty, fifo_full, fifo_drop, overflow_q;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    push_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (raw_valid) begin
          cand_d  = raw_key;
          cnt_d   = CNT_ONE;
          state_d = ARMING;
        end
      end
      ARMING: begin
        if (!raw_valid) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (raw_key != cand_q) begin
          cand_d = raw_key;
          cnt_d  = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            push_req = 1'b1;
            state_d  = HELD;
          end
        end
      end
      HELD: begin
        // Any key while held only restarts the release timer; no rollover.
        if (raw_valid) begin
          cnt_d = '0;
        end else begin
          cnt_d   = CNT_ONE;
          state_d = RELEASING;
        end
      end
      RELEASING: begin
        if (raw_valid) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_inc == CNT_MAX) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      overflow_q <= fifo_drop;
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (cand_q),
    .pop       (out_ready),
    .head      (out_key),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop),
    .count     (pending)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule
